garage_data_mem: RTL and testbench
==================================

// Module: garage_data_mem
// PURPOSE
//  Parametrised data-memory subsystem for the garage CPU: one synchronous RAM plus a memory-mapped I/O window.
//  Replaces the single-word reset write with a hardware clear engine that zeroes all RAM on reset and stalls the CPU meanwhile.
//  Sits between the CPU data port (addr/out_m/write_m/in_m) and the board LEDs and switches.
// PARAMETERS
//  DATA_WIDTH  16    word width of RAM, I/O registers and cycle counter
//  ADDR_WIDTH  10    CPU address width; RAM depth = IO_BASE words
//  IO_BASE     1020  first I/O address; legal range 1 <= IO_BASE <= 2**ADDR_WIDTH-3
// PORTS
//  Clk        in   1           system clock, all logic on rising edge
//  Reset      in   1           synchronous, active-high reset
//  cpu_addr   in   ADDR_WIDTH  CPU data address
//  cpu_wdata  in   DATA_WIDTH  CPU write data (out_m)
//  cpu_we     in   1           CPU write strobe (write_m)
//  cpu_rdata  out  DATA_WIDTH  read data (in_m), registered
//  stall      out  1           high while the clear engine runs; the CPU must hold
//  sw_in      in   DATA_WIDTH  asynchronous switch inputs
//  led_out    out  DATA_WIDTH  LED register
//  vid_addr   in   ADDR_WIDTH  video read address (see CONFIGURATION)
//  vid_rdata  out  DATA_WIDTH  video read data, registered
// BEHAVIOUR
//  Reset values: cpu_rdata=0, led_out=0, vid_rdata=0, counter=0, stall=1, FSM=CLEAR, clr_ptr=0, switch syncs=0.
//  FSM CLEAR:
//   - Each cycle writes 0 to RAM[clr_ptr], then clr_ptr++.
//   - After writing clr_ptr==IO_BASE-1, goes to RUN.
//   - stall=1 for exactly IO_BASE cycles after Reset is released.
//  FSM RUN:
//   - stall=0; stays in RUN until Reset.
//   - Reset asserted in any state, including mid-clear, restarts CLEAR from clr_ptr=0.
//  While stall=1: CPU writes are ignored, cpu_rdata is forced to 0, and the counter holds.
//  Address map (RUN), all reads with 1-cycle latency (addr at edge N -> cpu_rdata after edge N+1):
//   - addr <  IO_BASE: RAM, read-first (same-cycle write to the same addr returns the old word).
//   - IO_BASE+0: LED register, R/W; a write updates led_out on the next edge.
//   - IO_BASE+1: switches, read-only. sw_in passes a 2-flop synchroniser; a change is readable 3 cycles later. Writes are ignored.
//   - IO_BASE+2: free-running cycle counter, +1 per RUN cycle, wraps from all-ones to 0.
//     - Any write clears it to 0 (data ignored); the write wins over the increment in that cycle.
//   - addr >= IO_BASE+3: reads return 0, writes are ignored.
//  Arithmetic: unsigned; counter has exactly DATA_WIDTH bits. No X may reach any output after reset.
// CONFIGURATION
//  GARAGE_DMEM_VIDEO_PORT_EN defined:
//   - Second read-only RAM port for a display scanner.
//   - vid_rdata = RAM[vid_addr] one cycle after vid_addr; independent of the CPU port and never stalled.
//   - During CLEAR it returns the partially cleared contents.
//   - vid_addr >= IO_BASE reads 0.
//  Not defined: ports remain present; vid_addr is ignored, vid_rdata is constant 0 and no second port is inferred.
// TESTING
//  1 Reset 1 cycle, IO_BASE=1020 -> stall high for exactly 1020 cycles, then low; every RAM word reads 0.
//  2 Write 0x1234 to addr 5, read addr 5 the next cycle -> cpu_rdata=0x1234 one cycle later.
//    Write 0xBEEF and read addr 5 in the same cycle -> old 0x1234 returned.
//  3 Write 0x00A5 to IO_BASE -> led_out=0x00A5 after one edge.
//    sw_in 0x0000->0x8001, read IO_BASE+1 -> 0x8001 visible 3 cycles after the change.
//  4 Counter: preload by running to 0xFFFE, read for 3 cycles -> 0xFFFE, 0xFFFF, 0x0000.
//    Write to IO_BASE+2 while it increments -> next read 0x0000.
//  5 Reset mid-clear at clr_ptr=500 -> stall stays high 1020 more cycles after release; CPU writes during stall don't land.
//    Read IO_BASE+5 -> 0.
//  6 With GARAGE_DMEM_VIDEO_PORT_EN: CPU writes 0x0F0F to addr 9, vid_addr=9 -> vid_rdata=0x0F0F one cycle later, CPU unaffected.
//    Without the macro: vid_rdata stays 0.

Source files
------------

// File: rtl/garage_data_mem.sv
// garage_data_mem: data-memory subsystem for the garage CPU.
//
// One synchronous RAM of IO_BASE words plus a small memory-mapped I/O window.
// Out of reset a clear engine writes zero to every RAM word. It holds stall
// high while it runs, and the CPU must wait.
//
// Address map (all reads are registered, so data appears one edge after the address):
//   addr <  IO_BASE      RAM, read-first
//   IO_BASE + 0          LED register (R/W)
//   IO_BASE + 1          synchronised switches (RO)
//   IO_BASE + 2          free-running cycle counter, any write clears it
//   addr >= IO_BASE + 3  reads 0, writes ignored
//
// Ports:
//   Clk, Reset           clock and synchronous active-high reset
//   cpu_addr/cpu_wdata/cpu_we/cpu_rdata   CPU data port
//   stall                high while the clear engine runs
//   sw_in / led_out      board switches (async) and LED register
//   vid_addr / vid_rdata optional second read-only RAM port
//
// Build option: define GARAGE_DMEM_VIDEO_PORT_EN to enable the video read port.
// When it is not defined, vid_rdata is tied to 0 and vid_addr is ignored.

module garage_data_mem #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned IO_BASE    = 1020
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    input  logic                  cpu_we,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  stall,
    input  logic [DATA_WIDTH-1:0] sw_in,
    output logic [DATA_WIDTH-1:0] led_out,
    input  logic [ADDR_WIDTH-1:0] vid_addr,
    output logic [DATA_WIDTH-1:0] vid_rdata
);

    localparam logic [ADDR_WIDTH-1:0] IoLed    = ADDR_WIDTH'(IO_BASE);
    localparam logic [ADDR_WIDTH-1:0] IoSw     = ADDR_WIDTH'(IO_BASE + 1);
    localparam logic [ADDR_WIDTH-1:0] IoCnt    = ADDR_WIDTH'(IO_BASE + 2);
    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(IO_BASE - 1);

    typedef enum logic [0:0] {StClear, StRun} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_ptr_q, clr_ptr_d;
    logic                    stall_q, stall_d;
    logic [DATA_WIDTH-1:0]   led_q, led_d;
    logic [DATA_WIDTH-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   sw_sync1_q, sw_sync2_q;
    logic [DATA_WIDTH-1:0]   io_rd_q, io_rd_d;
    logic                    sel_ram_q, sel_ram_d;

    logic [DATA_WIDTH-1:0]   mem [IO_BASE];
    logic [DATA_WIDTH-1:0]   ram_rd_q;
    logic                    in_ram;
    logic                    ram_we;
    logic [ADDR_WIDTH-1:0]   ram_waddr;
    logic [ADDR_WIDTH-1:0]   ram_raddr;
    logic [DATA_WIDTH-1:0]   ram_wdata;

    // Clear engine sequencing
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        unique case (state_q)
            StClear: begin
                clr_ptr_d = clr_ptr_q + ADDR_WIDTH'(1);
                if (clr_ptr_q == LastAddr) begin
                    state_d   = StRun;
                    clr_ptr_d = '0;
                end
            end
            StRun:   state_d = StRun;
            default: state_d = StClear;
        endcase
        stall_d = (state_d == StClear);
    end

    // The clear engine owns the RAM write port while stalled.
    always_comb begin
        in_ram    = (cpu_addr < IoLed);
        ram_raddr = in_ram ? cpu_addr : '0;
        ram_we    = stall_q | (cpu_we & in_ram);
        ram_waddr = stall_q ? clr_ptr_q : cpu_addr;
        ram_wdata = stall_q ? '0 : cpu_wdata;
    end

    // I/O registers and read-select capture. Everything freezes while stalled.
    always_comb begin
        led_d     = led_q;
        cnt_d     = cnt_q;
        io_rd_d   = '0;
        sel_ram_d = 1'b0;
        if (!stall_q) begin
            if (cpu_we && cpu_addr == IoLed) begin
                led_d = cpu_wdata;
            end
            // A write clears the counter and takes priority over the increment.
            cnt_d = (cpu_we && cpu_addr == IoCnt) ? '0 : cnt_q + DATA_WIDTH'(1);
            if (in_ram) begin
                sel_ram_d = 1'b1;
            end else if (cpu_addr == IoLed) begin
                io_rd_d = led_q;
            end else if (cpu_addr == IoSw) begin
                io_rd_d = sw_sync2_q;
            end else if (cpu_addr == IoCnt) begin
                io_rd_d = cnt_q;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= StClear;
            clr_ptr_q  <= '0;
            stall_q    <= 1'b1;
            led_q      <= '0;
            cnt_q      <= '0;
            sw_sync1_q <= '0;
            sw_sync2_q <= '0;
            io_rd_q    <= '0;
            sel_ram_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            stall_q    <= stall_d;
            led_q      <= led_d;
            cnt_q      <= cnt_d;
            sw_sync1_q <= sw_in;
            sw_sync2_q <= sw_sync1_q;
            io_rd_q    <= io_rd_d;
            sel_ram_q  <= sel_ram_d;
        end
    end

    // Read-first RAM: the read sees the word before the same-edge write.
    always_ff @(posedge Clk) begin
        if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
        end
        ram_rd_q <= mem[ram_raddr];
    end

    // sel_ram_q masks the uninitialised RAM output until a real RAM read occurs.
    assign cpu_rdata = sel_ram_q ? ram_rd_q : io_rd_q;
    assign stall     = stall_q;
    assign led_out   = led_q;

`ifdef GARAGE_DMEM_VIDEO_PORT_EN
    logic                  vid_in_ram;
    logic [ADDR_WIDTH-1:0] vid_raddr;
    logic [DATA_WIDTH-1:0] vid_rd_q;
    logic                  vid_sel_q;

    assign vid_in_ram = (vid_addr < IoLed);
    assign vid_raddr  = vid_in_ram ? vid_addr : '0;

    always_ff @(posedge Clk) begin
        vid_rd_q <= mem[vid_raddr];
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            vid_sel_q <= 1'b0;
        end else begin
            vid_sel_q <= vid_in_ram;
        end
    end

    assign vid_rdata = vid_sel_q ? vid_rd_q : '0;
`else
    logic unused_vid_addr;
    assign unused_vid_addr = ^vid_addr;
    assign vid_rdata       = '0;
`endif

endmodule

// File: tb/tb_garage_data_mem.sv
module tb_garage_data_mem;

    localparam int unsigned DW      = 16;
    localparam int unsigned AW      = 10;
    localparam int unsigned IO_BASE = 1020;
    localparam logic [AW-1:0] IO_LED = AW'(IO_BASE);
    localparam logic [AW-1:0] IO_SW  = AW'(IO_BASE + 1);
    localparam logic [AW-1:0] IO_CNT = AW'(IO_BASE + 2);

    logic          Clk = 1'b0;
    logic          Reset;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_we;
    logic [DW-1:0] cpu_rdata;
    logic          stall;
    logic [DW-1:0] sw_in;
    logic [DW-1:0] led_out;
    logic [AW-1:0] vid_addr;
    logic [DW-1:0] vid_rdata;

    garage_data_mem #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .IO_BASE   (IO_BASE)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_we   (cpu_we),
        .cpu_rdata(cpu_rdata),
        .stall    (stall),
        .sw_in    (sw_in),
        .led_out  (led_out),
        .vid_addr (vid_addr),
        .vid_rdata(vid_rdata)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [DW-1:0] ram_m [IO_BASE];
    logic [DW-1:0] led_m, cnt_m, s1_m, s2_m;
    logic [AW-1:0] vid_a;

    typedef struct {
        string         tag;
        logic [DW-1:0] cpu;
        logic [DW-1:0] vid;
    } exp_t;
    exp_t sb_q[$];

    task automatic check_eq(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
        if (a < IO_LED)      return ram_m[a];
        else if (a == IO_LED) return led_m;
        else if (a == IO_SW)  return s2_m;
        else if (a == IO_CNT) return cnt_m;
        else                  return '0;
    endfunction

    function automatic logic [DW-1:0] model_vid(input logic [AW-1:0] a);
`ifdef GARAGE_DMEM_VIDEO_PORT_EN
        return (a < IO_LED) ? ram_m[a] : '0;
`else
        return (a == a) ? '0 : '1;
`endif
    endfunction

    // One clock edge; the switch synchroniser model advances with it.
    task automatic tick();
        s2_m = s1_m;
        s1_m = sw_in;
        @(posedge Clk);
        #1;
    endtask

    // One RUN-mode CPU cycle: expectation pushed at drive time, checked after the edge.
    task automatic step(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] wd,
                        input string tag);
        exp_t e;
        cpu_addr  = a;
        cpu_we    = we;
        cpu_wdata = wd;
        vid_addr  = vid_a;
        e.tag = tag;
        e.cpu = model_rd(a);
        e.vid = model_vid(vid_a);
        sb_q.push_back(e);
        if (we && a < IO_LED)  ram_m[a] = wd;
        if (we && a == IO_LED) led_m = wd;
        cnt_m = (we && a == IO_CNT) ? '0 : cnt_m + 16'd1;
        tick();
        e = sb_q.pop_front();
        check_eq({e.tag, "_rd"}, cpu_rdata, e.cpu);
        check_eq({e.tag, "_vid"}, vid_rdata, e.vid);
        check_eq({e.tag, "_led"}, led_out, led_m);
        check_eq({e.tag, "_stall"}, {15'd0, stall}, 16'd0);
    endtask

    task automatic do_reset();
        Reset  = 1'b1;
        cpu_we = 1'b0;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        for (int i = 0; i < int'(IO_BASE); i++) ram_m[i] = '0;
        led_m = '0;
        cnt_m = '0;
        s1_m  = '0;
        s2_m  = '0;
        check_eq("rst_stall", {15'd0, stall}, 16'd1);
        check_eq("rst_rdata", cpu_rdata, 16'd0);
        check_eq("rst_led", led_out, 16'd0);
        check_eq("rst_vid", vid_rdata, 16'd0);
    endtask

    // Counts stalled cycles (bounded); optionally hammers a write that must not land.
    task automatic count_stall(input logic wr, input string tag);
        int n = 0;
        while (stall === 1'b1 && n < 2000) begin
            cpu_addr  = 10'd7;
            cpu_we    = wr;
            cpu_wdata = 16'hDEAD;
            tick();
            n++;
            check_eq({tag, "_stall_rd"}, cpu_rdata, 16'd0);
        end
        check_eq({tag, "_stall_len"}, 16'(n), 16'(IO_BASE));
    endtask

    initial begin
        Reset     = 1'b1;
        cpu_addr  = '0;
        cpu_wdata = '0;
        cpu_we    = 1'b0;
        sw_in     = '0;
        vid_addr  = '0;
        vid_a     = '0;

        // Reset and full clear
        do_reset();
        count_stall(1'b0, "clr1");
        for (int i = 0; i < int'(IO_BASE); i++) step(AW'(i), 1'b0, '0, "zero");

        // RAM write/read, then read-first collision
        step(10'd5, 1'b1, 16'h1234, "wr5");
        step(10'd5, 1'b0, '0, "rd5");
        step(10'd5, 1'b1, 16'hBEEF, "wr_rd5_old");
        step(10'd5, 1'b0, '0, "rd5_new");
        step(10'd1019, 1'b1, 16'hA5A5, "wr_top");
        step(10'd1019, 1'b0, '0, "rd_top");

        // LED register
        step(IO_LED, 1'b1, 16'h00A5, "led_wr");
        check_eq("led_direct", led_out, 16'h00A5);
        step(IO_LED, 1'b0, '0, "led_rd");

        // Switch synchroniser latency
        step(IO_SW, 1'b1, 16'hFFFF, "sw_wr_ign");
        sw_in = 16'h8001;
        step(IO_SW, 1'b0, '0, "sw_lat1");
        step(IO_SW, 1'b0, '0, "sw_lat2");
        step(IO_SW, 1'b0, '0, "sw_lat3");
        check_eq("sw_visible", cpu_rdata, 16'h8001);

        // Unmapped window
        step(AW'(IO_BASE + 3), 1'b1, 16'h5555, "hole3");
        step(AW'(IO_BASE + 3), 1'b0, '0, "hole3_rd");
        step(10'd1023, 1'b0, '0, "hole_top");

        // Counter: clear, run to 0xFFFE, observe wrap, then write-wins clear
        step(IO_CNT, 1'b1, 16'h7777, "cnt_clr");
        while (cnt_m != 16'hFFFE) step(IO_CNT, 1'b0, '0, "cnt_run");
        step(IO_CNT, 1'b0, '0, "cnt_fffe");
        check_eq("cnt_fffe_abs", cpu_rdata, 16'hFFFE);
        step(IO_CNT, 1'b0, '0, "cnt_ffff");
        check_eq("cnt_ffff_abs", cpu_rdata, 16'hFFFF);
        step(IO_CNT, 1'b0, '0, "cnt_wrap");
        check_eq("cnt_wrap_abs", cpu_rdata, 16'h0000);
        repeat (3) step(IO_CNT, 1'b0, '0, "cnt_more");
        step(IO_CNT, 1'b1, 16'h1111, "cnt_wr");
        step(IO_CNT, 1'b0, '0, "cnt_after_wr");
        check_eq("cnt_after_wr_abs", cpu_rdata, 16'h0000);

        // Video port
        vid_a = 10'd9;
        step(10'd9, 1'b1, 16'h0F0F, "vid_wr9");
        step(10'd9, 1'b0, '0, "vid_rd9");
        vid_a = 10'd5;
        step(10'd20, 1'b0, '0, "vid_rd5");
        vid_a = IO_LED;
        step(10'd9, 1'b0, '0, "vid_io");
        vid_a = '0;

        // Reset mid-clear at clr_ptr = 500, writes during stall must not land
        sw_in = '0;
        step(10'd7, 1'b1, 16'h4242, "pre_wr7");
        do_reset();
        repeat (500) tick();
        check_eq("mid_stall", {15'd0, stall}, 16'd1);
        do_reset();
        count_stall(1'b1, "clr2");
        step(10'd7, 1'b0, '0, "rd7_after");
        step(10'd5, 1'b0, '0, "rd5_after");
        step(IO_LED, 1'b0, '0, "led_after");
        step(AW'(IO_BASE + 5), 1'b0, '0, "hole5");
        check_eq("hole5_abs", cpu_rdata, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
